down_counter: RTL and testbench

DOWN_COUNTER -- requirements
Module: down_counter

---
 rtl/down_counter.sv | 121 ++++++++++++
 tb/tb_down_counter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/down_counter.sv
// -----------------------------------------------------------------------------
// down_counter
//
// N-bit loadable down counter with a small expiry FSM (IDLE / RUN / EXPIRED).
// A decrement from zero either wraps to all-ones (with a one-cycle borrow
// pulse) or saturates at zero, depending on dc_hold_zero. Reaching zero by
// counting down from 1 while running produces a one-cycle dc_done pulse.
//
// Per-edge priority: dc_clear > dc_load > dc_e > hold.
//
// Ports
//   dc_clk        in   1  clock, all state updates on the rising edge
//   dc_clear      in   1  synchronous active-high clear
//   dc_e          in   1  decrement enable
//   dc_load       in   1  parallel-load strobe
//   dc_d          in   N  parallel-load value
//   dc_hold_zero  in   1  1 = saturate at zero, 0 = wrap to all-ones
//   dc_q          out  N  registered count
//   dc_zero       out  1  combinational, 1 when dc_q == 0
//   dc_bout       out  1  registered borrow-out pulse (wrap from zero)
//   dc_busy       out  1  registered, 1 while the FSM is in RUN
//   dc_done       out  1  registered expiry pulse (RUN count reached zero)
//   dc_state      out  2  debug view of the FSM state
//                         (0 = IDLE, 1 = RUN, 2 = EXPIRED)
//
// No handshakes: every input is sampled on each rising edge of dc_clk.
// -----------------------------------------------------------------------------
module down_counter #(
    parameter int N = 4
) (
    input  logic         dc_clk,
    input  logic         dc_clear,
    input  logic         dc_e,
    input  logic         dc_load,
    input  logic [N-1:0] dc_d,
    input  logic         dc_hold_zero,
    output logic [N-1:0] dc_q,
    output logic         dc_zero,
    output logic         dc_bout,
    output logic         dc_busy,
    output logic         dc_done,
    output logic [1:0]   dc_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t       state;
    state_t       state_next;
    logic [N-1:0] q_next;
    logic         bout_next;
    logic         done_next;
    logic         busy_next;

    // Decode of the enabled action; a load masks any decrement in the same cycle.
    logic dec;
    logic at_zero;
    logic wrap;
    logic to_zero;

    assign dec     = dc_e && !dc_load;
    assign at_zero = (dc_q == '0);
    assign wrap    = dec && at_zero && !dc_hold_zero;
    assign to_zero = dec && (dc_q == ONE);

    // State / count register. Clear overrides everything else.
    always_ff @(posedge dc_clk) begin
        if (dc_clear) begin
            state   <= IDLE;
            dc_q    <= '0;
            dc_bout <= 1'b0;
            dc_done <= 1'b0;
            dc_busy <= 1'b0;
        end else begin
            state   <= state_next;
            dc_q    <= q_next;
            dc_bout <= bout_next;
            dc_done <= done_next;
            dc_busy <= busy_next;
        end
    end

    // Next-state and next-count logic.
    always_comb begin
        state_next = state;
        q_next     = dc_q;
        if (dc_load) begin
            q_next     = dc_d;
            // Loading zero is an immediate, silent expiry.
            state_next = (dc_d != '0) ? RUN : EXPIRED;
        end else if (dc_e) begin
            if (at_zero) begin
                if (!dc_hold_zero) begin
                    q_next     = '1;
                    state_next = RUN;
                end
            end else begin
                q_next = dc_q - ONE;
                if (to_zero && (state == RUN)) begin
                    state_next = EXPIRED;
                end
            end
        end
    end

    // Next values of the registered status outputs.
    always_comb begin
        bout_next = wrap;
        done_next = to_zero && (state == RUN);
        busy_next = (state_next == RUN);
    end

    assign dc_zero  = at_zero;
    assign dc_state = state;

endmodule

// File: tb/tb_down_counter.sv
// -----------------------------------------------------------------------------
// tb_down_counter
//
// Directed scenarios followed by random stimulus on down_counter (N = 4).
// A behavioural reference model (plain integer arithmetic on the count and a
// state number) predicts every output after each clock edge.
// -----------------------------------------------------------------------------
module tb_down_counter;

    localparam int N   = 4;
    localparam int MOD = 1 << N;

    localparam int M_IDLE    = 0;
    localparam int M_RUN     = 1;
    localparam int M_EXPIRED = 2;

    // ---------------- clock / DUT signals ----------------
    logic         dc_clk = 1'b0;
    logic         dc_clear = 1'b1;
    logic         dc_e = 1'b0;
    logic         dc_load = 1'b0;
    logic [N-1:0] dc_d = '0;
    logic         dc_hold_zero = 1'b0;
    logic [N-1:0] dc_q;
    logic         dc_zero;
    logic         dc_bout;
    logic         dc_busy;
    logic         dc_done;
    logic [1:0]   dc_state;

    always #5 dc_clk = ~dc_clk;

    down_counter #(.N(N)) dut (
        .dc_clk       (dc_clk),
        .dc_clear     (dc_clear),
        .dc_e         (dc_e),
        .dc_load      (dc_load),
        .dc_d         (dc_d),
        .dc_hold_zero (dc_hold_zero),
        .dc_q         (dc_q),
        .dc_zero      (dc_zero),
        .dc_bout      (dc_bout),
        .dc_busy      (dc_busy),
        .dc_done      (dc_done),
        .dc_state     (dc_state)
    );

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    int m_q     = 0;
    int m_state = M_IDLE;
    int m_bout  = 0;
    int m_done  = 0;

    // Apply one clock edge worth of behaviour to the model.
    task automatic model_step(input int clr, input int ld, input int en,
                              input int d, input int hz);
        m_bout = 0;
        m_done = 0;
        if (clr != 0) begin
            m_q     = 0;
            m_state = M_IDLE;
        end else if (ld != 0) begin
            m_q     = d;
            m_state = (d != 0) ? M_RUN : M_EXPIRED;
        end else if (en != 0) begin
            if (m_q == 0) begin
                if (hz == 0) begin
                    m_q     = MOD - 1;
                    m_bout  = 1;
                    m_state = M_RUN;
                end
            end else begin
                m_q = m_q - 1;
                if (m_q == 0 && m_state == M_RUN) begin
                    m_done  = 1;
                    m_state = M_EXPIRED;
                end
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".q"},     32'(dc_q),     32'(m_q));
        chk({tag, ".zero"},  32'(dc_zero),  32'(m_q == 0));
        chk({tag, ".bout"},  32'(dc_bout),  32'(m_bout));
        chk({tag, ".done"},  32'(dc_done),  32'(m_done));
        chk({tag, ".busy"},  32'(dc_busy),  32'(m_state == M_RUN));
        chk({tag, ".state"}, 32'(dc_state), 32'(m_state));
    endtask

    // ---------------- driver ----------------
    // Drive on the falling edge, let one rising edge pass, check 1 ns later.
    task automatic cycle(input string tag, input int clr, input int ld, input int en,
                         input int d, input int hz);
        @(negedge dc_clk);
        dc_clear     = 1'(clr);
        dc_load      = 1'(ld);
        dc_e         = 1'(en);
        dc_d         = N'(d);
        dc_hold_zero = 1'(hz);
        model_step(clr, ld, en, d, hz);
        @(posedge dc_clk);
        #1;
        check_all(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset
        cycle("rst0", 1, 0, 0, 0, 0);
        cycle("rst1", 1, 1, 1, 7, 0);
        chk("rst.q_const", 32'(dc_q), 32'd0);
        chk("rst.zero_const", 32'(dc_zero), 32'd1);

        // Load 3 then count 3,2,1,0 with expiry pulse at zero
        cycle("r31.load", 0, 1, 1, 3, 0);
        chk("r31.q3", 32'(dc_q), 32'd3);
        cycle("r31.dec2", 0, 0, 1, 0, 0);
        cycle("r31.dec1", 0, 0, 1, 0, 0);
        cycle("r31.dec0", 0, 0, 1, 0, 0);
        chk("r31.done_const", 32'(dc_done), 32'd1);
        chk("r31.busy_const", 32'(dc_busy), 32'd0);
        cycle("r31.idle", 0, 0, 0, 0, 0);
        chk("r31.done_gone", 32'(dc_done), 32'd0);

        // Wrap from zero (in EXPIRED)
        cycle("r32.wrap", 0, 0, 1, 0, 0);
        chk("r32.q15", 32'(dc_q), 32'd15);
        chk("r32.bout_const", 32'(dc_bout), 32'd1);
        cycle("r32.after", 0, 0, 0, 0, 0);
        chk("r32.bout_gone", 32'(dc_bout), 32'd0);

        // Wrap from IDLE also enters RUN
        cycle("idle.clr", 1, 0, 0, 0, 0);
        cycle("idle.wrap", 0, 0, 1, 0, 0);

        // Saturate at zero
        cycle("r33.clr", 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle("r33.sat", 0, 0, 1, 0, 1);
        chk("r33.q0", 32'(dc_q), 32'd0);

        // Load wins over decrement-to-zero
        cycle("r34.load1", 0, 1, 0, 1, 0);
        cycle("r34.race", 0, 1, 1, 9, 0);
        chk("r34.q9", 32'(dc_q), 32'd9);
        chk("r34.done0", 32'(dc_done), 32'd0);

        // Clear mid-count aborts without done
        cycle("r35.load12", 0, 1, 0, 12, 0);
        for (int i = 0; i < 5; i++) cycle("r35.dec", 0, 0, 1, 0, 0);
        chk("r35.q7", 32'(dc_q), 32'd7);
        cycle("r35.clr", 1, 1, 1, 5, 0);
        chk("r35.clr_q", 32'(dc_q), 32'd0);
        cycle("r35.hold", 0, 0, 0, 5, 0);

        // Loading zero expires silently
        cycle("r36.load0", 0, 1, 1, 0, 0);
        chk("r36.busy0", 32'(dc_busy), 32'd0);

        // Random stimulus
        for (int i = 0; i < 400; i++) begin
            int clr;
            int ld;
            int en;
            int d;
            int hz;
            clr = ($urandom_range(0, 31) == 0) ? 1 : 0;
            ld  = ($urandom_range(0, 5) == 0) ? 1 : 0;
            en  = ($urandom_range(0, 3) != 0) ? 1 : 0;
            d   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1) : $urandom_range(0, MOD - 1);
            hz  = $urandom_range(0, 1);
            cycle("rand", clr, ld, en, d, hz);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
